// File: rtl/frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_pkg
// Description : Frame buffer geometry, arbiter state/player enums and the
//               pixel-to-word address and colour-pair packing helpers.
// Revision    : 1.0  initial release
// ============================================================================
package frame_pkg;

  localparam int unsigned H_PIX   = 640;
  localparam int unsigned V_LINES = 480;
  localparam int unsigned H_WORDS = 320;
  localparam int unsigned N_WORDS = H_WORDS * V_LINES;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fwa_state_t;

  typedef enum logic {
    BLUE = 1'b0,
    RED  = 1'b1
  } player_t;

  // Word address of the pixel pair holding (x, y); y*320 built from shifts.
  function automatic logic [18:0] pix_to_addr(input logic [9:0] x, input logic [9:0] y);
    logic [18:0] y_w;
    y_w = {9'd0, y};
    return (y_w << 8) + (y_w << 6) + {10'd0, x[9:1]};
  endfunction

  // Both pixels of a word get the same colour nibble.
  function automatic logic [15:0] pack_pair(input logic [3:0] color);
    return {4'h0, color, 4'h0, color};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin arbiter. Combinational one-hot grant,
//               registered record of the last winner (BLUE=0, RED=1).
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter2
  import frame_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic [1:0] block,
  input  logic       advance,
  output logic [1:0] grant,
  output player_t    rr_last
);

  logic [1:0] elig;
  player_t    rr_last_q;
  player_t    rr_last_d;

  // Grant the single eligible requester, or on a tie the one that lost last time
  always_comb begin
    elig  = req & ~block;
    grant = elig;
    if (elig == 2'b11) begin
      grant = (rr_last_q == RED) ? 2'b01 : 2'b10;
    end
  end

  // Remember the winner only when the grant is actually consumed
  always_comb begin
    rr_last_d = rr_last_q;
    if (advance && grant[0]) begin
      rr_last_d = BLUE;
    end else if (advance && grant[1]) begin
      rr_last_d = RED;
    end
  end

  // Last-winner register; RED after reset so BLUE takes the first tie
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rr_last_q <= RED;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

  assign rr_last = rr_last_q;

endmodule
`default_nettype wire

// File: rtl/frame_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : frame_write_arbiter
// Description : Sole owner of the frameRAM write port. Runs the full-screen
//               clear sweep and arbitrates blue/red trail pixel writes.
// Revision    : 1.0  initial release
// ============================================================================
module frame_write_arbiter
  import frame_pkg::*;
#(
  parameter int unsigned LINES = V_LINES
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        clear_start,
  input  logic [3:0]  bg_color,
  output logic        clear_busy,
  output logic        clear_done,
  input  logic        blue_req,
  input  logic [9:0]  blue_x,
  input  logic [9:0]  blue_y,
  input  logic [3:0]  blue_color,
  output logic        blue_ack,
  input  logic        red_req,
  input  logic [9:0]  red_x,
  input  logic [9:0]  red_y,
  input  logic [3:0]  red_color,
  output logic        red_ack,
  output logic        drop,
  output logic        WE,
  output logic [18:0] write_address,
  output logic [15:0] Data_In
);

  localparam int unsigned N_LOCAL   = H_WORDS * LINES;
  localparam logic [17:0] LAST_WORD = 18'(N_LOCAL - 1);

  fwa_state_t  state_q;
  logic [17:0] cnt_q;
  logic        we_q;
  logic [18:0] addr_q;
  logic [15:0] data_q;
  logic        busy_q;
  logic        done_q;
  logic        back_q;
  logic        rack_q;
  logic        drop_q;
  logic        grant_vld_q;

  logic [1:0]  grant;
  logic [1:0]  block;
  logic        advance;
  player_t     rr_last;

  logic [9:0]  sel_x;
  logic [9:0]  sel_y;
  logic [3:0]  sel_color;
  logic        sel_in_range;
  logic [18:0] sel_addr;

  // The requester served last cycle still shows its (stale) req; keep it out
  always_comb begin
    block = 2'b00;
    if (grant_vld_q) begin
      block = (rr_last == BLUE) ? 2'b01 : 2'b10;
    end
    advance = (state_q == IDLE) && !clear_start;
  end

  rr_arbiter2 u_arb (
    .Clk     (Clk),
    .Reset   (Reset),
    .req     ({red_req, blue_req}),
    .block   (block),
    .advance (advance),
    .grant   (grant),
    .rr_last (rr_last)
  );

  // Route the granted requester's pixel to the write path and range-check it
  always_comb begin
    sel_x        = grant[1] ? red_x     : blue_x;
    sel_y        = grant[1] ? red_y     : blue_y;
    sel_color    = grant[1] ? red_color : blue_color;
    sel_in_range = (sel_x < 10'(H_PIX)) && (sel_y < 10'(LINES));
    sel_addr     = pix_to_addr(sel_x, sel_y);
  end

  // Write-port sequencer: clear sweep has absolute priority over trail writes.
  // Word 0 is issued on the start cycle so busy and the first write line up.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      back_q      <= 1'b0;
      rack_q      <= 1'b0;
      drop_q      <= 1'b0;
      grant_vld_q <= 1'b0;
    end else begin
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      back_q      <= 1'b0;
      rack_q      <= 1'b0;
      drop_q      <= 1'b0;
      grant_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (clear_start) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= '0;
            data_q  <= pack_pair(bg_color);
            cnt_q   <= 18'd1;
          end else if (|grant) begin
            grant_vld_q <= 1'b1;
            back_q      <= grant[0];
            rack_q      <= grant[1];
            if (sel_in_range) begin
              we_q   <= 1'b1;
              addr_q <= sel_addr;
              data_q <= pack_pair(sel_color);
            end else begin
              drop_q <= 1'b1;
            end
          end
        end
        CLEAR: begin
          we_q   <= 1'b1;
          addr_q <= {1'b0, cnt_q};
          data_q <= pack_pair(bg_color);
          cnt_q  <= cnt_q + 18'd1;
          if (cnt_q == LAST_WORD) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign WE            = we_q;
  assign write_address = addr_q;
  assign Data_In       = data_q;
  assign clear_busy    = busy_q;
  assign clear_done    = done_q;
  assign blue_ack      = back_q;
  assign red_ack       = rack_q;
  assign drop          = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_write_arbiter
// Description : Self-checking bench. Full-size instance for trail writes,
//               reduced-height instance (16 lines) for clear sweeps.
// Revision    : 1.0  initial release
// ============================================================================
module tb_frame_write_arbiter;

  localparam int unsigned S_LINES = 16;
  localparam int unsigned S_WORDS = 320 * 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr_f, clr_s;
  logic [3:0]  bg;
  logic        breq, rreq;
  logic [9:0]  bx, by, rx, ry;
  logic [3:0]  bc, rc;

  logic        f_busy, f_done, f_back, f_rack, f_drop, f_we;
  logic [18:0] f_addr;
  logic [15:0] f_data;
  logic        s_busy, s_done, s_back, s_rack, s_drop, s_we;
  logic [18:0] s_addr;
  logic [15:0] s_data;

  frame_write_arbiter dut (
    .Clk(clk), .Reset(rst), .clear_start(clr_f), .bg_color(bg),
    .clear_busy(f_busy), .clear_done(f_done),
    .blue_req(breq), .blue_x(bx), .blue_y(by), .blue_color(bc), .blue_ack(f_back),
    .red_req(rreq), .red_x(rx), .red_y(ry), .red_color(rc), .red_ack(f_rack),
    .drop(f_drop), .WE(f_we), .write_address(f_addr), .Data_In(f_data)
  );

  frame_write_arbiter #(.LINES(S_LINES)) dut_s (
    .Clk(clk), .Reset(rst), .clear_start(clr_s), .bg_color(bg),
    .clear_busy(s_busy), .clear_done(s_done),
    .blue_req(breq), .blue_x(bx), .blue_y(by), .blue_color(bc), .blue_ack(s_back),
    .red_req(rreq), .red_x(rx), .red_y(ry), .red_color(rc), .red_ack(s_rack),
    .drop(s_drop), .WE(s_we), .write_address(s_addr), .Data_In(s_data)
  );

  typedef struct {
    logic        red;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [3:0]  c;
    logic        we;
    logic        drp;
    logic [18:0] addr;
    logic [15:0] data;
  } vec_t;

  vec_t vecs [8];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    breq = 1'b0;
    rreq = 1'b0;
    clr_s = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   early;
    logic got, found, seen;

    vecs[0] = '{1'b0, 10'd101,  10'd2,    4'h3, 1'b1, 1'b0, 19'd690,    16'h0303};
    vecs[1] = '{1'b1, 10'd0,    10'd0,    4'h5, 1'b1, 1'b0, 19'd0,      16'h0505};
    vecs[2] = '{1'b0, 10'd639,  10'd479,  4'hF, 1'b1, 1'b0, 19'd153599, 16'h0F0F};
    vecs[3] = '{1'b1, 10'd640,  10'd10,   4'h7, 1'b0, 1'b1, 19'd0,      16'h0000};
    vecs[4] = '{1'b1, 10'd5,    10'd480,  4'h7, 1'b0, 1'b1, 19'd0,      16'h0000};
    vecs[5] = '{1'b0, 10'd1023, 10'd1023, 4'h1, 1'b0, 1'b1, 19'd0,      16'h0000};
    vecs[6] = '{1'b1, 10'd320,  10'd100,  4'hA, 1'b1, 1'b0, 19'd32160,  16'h0A0A};
    vecs[7] = '{1'b0, 10'd1,    10'd1,    4'h2, 1'b1, 1'b0, 19'd320,    16'h0202};

    clr_f = 1'b0; clr_s = 1'b0; bg = 4'h0;
    breq = 1'b0; rreq = 1'b0;
    bx = '0; by = '0; bc = '0; rx = '0; ry = '0; rc = '0;
    do_reset();

    // Reset state
    chk("rst_f_ctrl", {f_we, f_busy, f_done, f_back, f_rack, f_drop}, 0);
    chk("rst_f_bus",  {f_addr, f_data}, 0);
    chk("rst_s_ctrl", {s_we, s_busy, s_done, s_back, s_rack, s_drop}, 0);

    // Single-requester vectors on the full-size instance, req held through ack
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      if (v.red) begin
        rreq = 1'b1; rx = v.x; ry = v.y; rc = v.c;
      end else begin
        breq = 1'b1; bx = v.x; by = v.y; bc = v.c;
      end
      step();
      chk($sformatf("vec%0d_ack", i), {f_back, f_rack}, {~v.red, v.red});
      chk($sformatf("vec%0d_we_drop", i), {f_we, f_drop}, {v.we, v.drp});
      if (v.we) begin
        chk($sformatf("vec%0d_addr", i), f_addr, v.addr);
        chk($sformatf("vec%0d_data", i), f_data, v.data);
      end
      step();
      chk($sformatf("vec%0d_no_regrant", i), {f_we, f_back, f_rack, f_drop}, 0);
      breq = 1'b0;
      rreq = 1'b0;
    end

    // Both requesting continuously: blue first, then strict alternation
    do_reset();
    bx = 10'd2; by = 10'd0; bc = 4'h1;
    rx = 10'd4; ry = 10'd0; rc = 4'h2;
    breq = 1'b1; rreq = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("alt%0d_ack", k), {f_back, f_rack}, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk($sformatf("alt%0d_wr", k), {f_we, f_addr, f_data},
          (k % 2 == 0) ? {1'b1, 19'd1, 16'h0101} : {1'b1, 19'd2, 16'h0202});
    end
    breq = 1'b0; rreq = 1'b0;
    step();

    // Full clear sweep on the reduced instance; a mid-sweep start is ignored
    do_reset();
    bg = 4'h8;
    clr_s = 1'b1;
    step();
    clr_s = 1'b0;
    for (int i = 0; i < S_WORDS; i++) begin
      chk("clr_sweep", {s_busy, s_we, s_done, s_addr, s_data},
          {1'b1, 1'b1, (i == S_WORDS - 1), 19'(i), 16'h0808});
      clr_s = (i == 99);
      step();
    end
    clr_s = 1'b0;
    chk("clr_end", {s_busy, s_we, s_done}, 0);

    // Red request raised mid-sweep waits for clear_done
    step();
    rx = 10'd10; ry = 10'd3; rc = 4'h4;
    clr_s = 1'b1;
    step();
    clr_s = 1'b0;
    early = 0;
    for (int i = 0; i < S_WORDS; i++) begin
      if (s_rack) early++;
      if (i == 5) rreq = 1'b1;
      step();
    end
    chk("clr_red_held", early, 0);
    got = 1'b0;
    for (int k = 0; k < 2 && !got; k++) begin
      if (s_rack) got = 1'b1;
      else step();
    end
    chk("red_after_clr_ack", got, 1);
    chk("red_after_clr_wr", {s_we, s_addr, s_data}, {1'b1, 19'd965, 16'h0404});
    rreq = 1'b0;
    step();

    // Reset while the sweep is at word 1000, then restart from 0
    do_reset();
    clr_s = 1'b1;
    step();
    clr_s = 1'b0;
    found = 1'b0;
    for (int i = 0; i < S_WORDS && !found; i++) begin
      if (s_addr == 19'd1000) found = 1'b1;
      else step();
    end
    chk("rst_mid_reached", found, 1);
    rst = 1'b1;
    step();
    chk("rst_mid_clear", {s_we, s_busy, s_done}, 0);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (s_done || s_we || s_busy) seen = 1'b1;
    end
    chk("rst_mid_quiet", seen, 0);
    clr_s = 1'b1;
    step();
    clr_s = 1'b0;
    chk("restart_first", {s_busy, s_we, s_addr}, {1'b1, 1'b1, 19'd0});
    step();
    chk("restart_second", {s_we, s_addr}, {1'b1, 19'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
